bp_be_dcache_wbuf_queue: RTL

- Parametrised successor to the two-entry dcache write buffer.
- Holds up to els_p pending store writes between the TV stage and the data-memory write port, in FIFO order.
- Can coalesce a new store into the youngest entry when both target the same dword.
- Forwards byte-merged store data to loads across all entries, and flags index conflicts with engine/fill packets.

---
 rtl/bp_be_dcache_wbuf_queue_pkg.sv | 25 ++
 rtl/bp_be_dcache_wbuf_queue_if.sv | 16 +
 rtl/bp_be_dcache_wbuf_queue_bypass.sv | 49 ++++
 rtl/bp_be_dcache_wbuf_queue.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bp_be_dcache_wbuf_queue_pkg.sv
// rtl/bp_be_dcache_wbuf_queue_pkg.sv - shared widths, entry layout helpers and default entry struct
package bp_be_dcache_wbuf_queue_pkg;

  localparam int wbuf_caddr_width_gp = 40;
  localparam int wbuf_dword_width_gp = 64;
  localparam int wbuf_assoc_gp       = 8;

  function automatic int wbuf_way_width(input int assoc);
    return (assoc > 1) ? $clog2(assoc) : 1;
  endfunction

  // Entry is packed MSB-first as {snoop, way_id, caddr, data, mask}
  function automatic int wbuf_entry_width(input int caddr_w, input int dword_w, input int assoc);
    return 1 + wbuf_way_width(assoc) + caddr_w + dword_w + dword_w / 8;
  endfunction

  typedef struct packed {
    logic                                        snoop;
    logic [wbuf_way_width(wbuf_assoc_gp)-1:0]    way_id;
    logic [wbuf_caddr_width_gp-1:0]              caddr;
    logic [wbuf_dword_width_gp-1:0]              data;
    logic [wbuf_dword_width_gp/8-1:0]            mask;
  } wbuf_entry_s;

endpackage

// File: rtl/bp_be_dcache_wbuf_queue_if.sv
// rtl/bp_be_dcache_wbuf_queue_if.sv - store-in / head-out handshake bundle of the write buffer
interface bp_be_dcache_wbuf_queue_if
  import bp_be_dcache_wbuf_queue_pkg::*;
#(
  parameter int entry_width_p = wbuf_entry_width(wbuf_caddr_width_gp, wbuf_dword_width_gp, wbuf_assoc_gp)
);
  logic                     v_i;
  logic [entry_width_p-1:0] entry_i;
  logic                     v_o;
  logic [entry_width_p-1:0] entry_o;
  logic                     yumi_i;
  logic                     force_o;

  modport slave  (input v_i, entry_i, yumi_i, output v_o, entry_o, force_o);
  modport master (output v_i, entry_i, yumi_i, input v_o, entry_o, force_o);
endinterface

// File: rtl/bp_be_dcache_wbuf_queue_bypass.sv
// rtl/bp_be_dcache_wbuf_queue_bypass.sv - age-ordered byte merge of hitting entries, registered into TV stage
module bp_be_dcache_wbuf_bypass #(
  parameter int n_p           = 5,
  parameter int dword_width_p = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [n_p-1:0]             hit_i,
  input  logic [dword_width_p-1:0]   data_i [n_p],
  input  logic [dword_width_p/8-1:0] mask_i [n_p],
  input  logic [dword_width_p-1:0]   data_tv_i,
  output logic [dword_width_p-1:0]   data_merged_o
);
  localparam int mask_w = dword_width_p / 8;

  logic [dword_width_p-1:0] data_d, data_q;
  logic [mask_w-1:0]        mask_d, mask_q;

  // Index 0 is youngest; walk oldest first so younger bytes overwrite.
  always_comb begin
    data_d = '0;
    mask_d = '0;
    for (int k = n_p - 1; k >= 0; k--) begin
      for (int b = 0; b < mask_w; b++) begin
        if (hit_i[k] && mask_i[k][b]) begin
          data_d[8*b +: 8] = data_i[k][8*b +: 8];
          mask_d[b]        = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_q <= '0;
      mask_q <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    data_merged_o = data_tv_i;
    for (int b = 0; b < mask_w; b++) begin
      if (mask_q[b]) data_merged_o[8*b +: 8] = data_q[8*b +: 8];
    end
  end
endmodule

// File: rtl/bp_be_dcache_wbuf_queue.sv
// rtl/bp_be_dcache_wbuf_queue.sv - els_p-deep dcache store buffer with coalescing, load forwarding and snoop check
module bp_be_dcache_wbuf_queue
  import bp_be_dcache_wbuf_queue_pkg::*;
#(
  parameter int els_p                = 4,
  parameter int caddr_width_p        = 40,
  parameter int dword_width_p        = 64,
  parameter int assoc_p              = 8,
  parameter int sets_p               = 64,
  parameter int block_offset_width_p = 6,
  parameter int coalesce_p           = 1,
  parameter int hwm_p                = 3
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  bp_be_dcache_wbuf_queue_if.slave     wbuf_if,
  output logic                         drain_o,
  output logic [$clog2(els_p+1)-1:0]   count_o,
  input  logic                         v_tl_i,
  input  logic [caddr_width_p-1:0]     addr_tl_i,
  input  logic [dword_width_p-1:0]     data_tv_i,
  output logic [dword_width_p-1:0]     data_merged_o,
  input  logic                         snoop_v_i,
  input  logic [$clog2(sets_p)-1:0]    snoop_index_i,
  output logic                         snoop_match_o
);
  localparam int mask_w   = dword_width_p / 8;
  localparam int off_w    = $clog2(mask_w);
  localparam int sidx_w   = $clog2(sets_p);
  localparam int ptr_w    = $clog2(els_p);
  localparam int cnt_w    = $clog2(els_p + 1);
  localparam int entry_w  = wbuf_entry_width(caddr_width_p, dword_width_p, assoc_p);
  localparam int data_lo  = mask_w;
  localparam int caddr_lo = mask_w + dword_width_p;
  localparam int tag_lo   = caddr_lo + off_w;

  function automatic logic [ptr_w-1:0] ptr_step(input logic [ptr_w-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s < 0) s = s + els_p;
    else if (s >= els_p) s = s - els_p;
    return ptr_w'(s);
  endfunction

  logic [entry_w-1:0] mem_q [els_p];
  logic [entry_w-1:0] mem_d [els_p];
  logic [ptr_w-1:0]   head_q, head_d, tail_q, tail_d, last_ptr;
  logic [cnt_w-1:0]   count_q, count_d;
  logic               drain_q, drain_d;
  logic               empty, full, pop, push, coalesce;
  logic [entry_w-1:0] tail_entry, merged_entry;

  assign empty      = (count_q == '0);
  assign full       = (count_q == cnt_w'(els_p));
  assign last_ptr   = ptr_step(tail_q, -1);
  assign tail_entry = mem_q[last_ptr];
  assign pop        = wbuf_if.yumi_i & ~empty;

  // Tag slice covers snoop, way_id and the dword part of caddr. When the tail is
  // also the departing head, merging would modify an entry already handed out.
  always_comb begin
    coalesce = 1'b0;
    if (coalesce_p != 0 && wbuf_if.v_i && !empty && !(count_q == cnt_w'(1) && wbuf_if.yumi_i))
      coalesce = (tail_entry[entry_w-1:tag_lo] == wbuf_if.entry_i[entry_w-1:tag_lo]);
  end

  assign push = wbuf_if.v_i & ~coalesce & ~(empty & wbuf_if.yumi_i);

  always_comb begin
    merged_entry = tail_entry;
    for (int b = 0; b < mask_w; b++) begin
      if (wbuf_if.entry_i[b]) merged_entry[data_lo + 8*b +: 8] = wbuf_if.entry_i[data_lo + 8*b +: 8];
    end
    merged_entry[mask_w-1:0] = tail_entry[mask_w-1:0] | wbuf_if.entry_i[mask_w-1:0];
  end

  always_comb begin
    mem_d = mem_q;
    if (coalesce) mem_d[last_ptr] = merged_entry;
    if (push)     mem_d[tail_q]   = wbuf_if.entry_i;
    head_d  = pop  ? ptr_step(head_q, 1) : head_q;
    tail_d  = push ? ptr_step(tail_q, 1) : tail_q;
    count_d = count_q + cnt_w'(push) - cnt_w'(pop);
    drain_d = (count_d >= cnt_w'(hwm_p));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drain_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drain_q <= drain_d;
    end
  end

  always_ff @(posedge clk_i) mem_q <= mem_d;

  assign wbuf_if.v_o     = reset_n_i & (empty ? wbuf_if.v_i : 1'b1);
  assign wbuf_if.entry_o = empty ? wbuf_if.entry_i : mem_q[head_q];
  assign wbuf_if.force_o = reset_n_i & wbuf_if.v_i & full;
  assign drain_o         = drain_q;
  assign count_o         = count_q;

  // Age order: slot 0 is the incoming store, slot k+1 is k entries older than the tail.
  logic [els_p:0]           age_v, age_snoop, age_hit;
  logic [caddr_width_p-1:0] age_caddr [els_p+1];
  logic [dword_width_p-1:0] age_data  [els_p+1];
  logic [mask_w-1:0]        age_mask  [els_p+1];
  logic                     snoop_hit;

  assign age_v[0]     = wbuf_if.v_i;
  assign age_snoop[0] = wbuf_if.entry_i[entry_w-1];
  assign age_caddr[0] = wbuf_if.entry_i[caddr_lo +: caddr_width_p];
  assign age_data[0]  = wbuf_if.entry_i[data_lo +: dword_width_p];
  assign age_mask[0]  = wbuf_if.entry_i[mask_w-1:0];

  for (genvar k = 0; k < els_p; k++) begin : g_age
    assign age_v[k+1]     = (count_q > cnt_w'(k));
    assign age_snoop[k+1] = mem_q[ptr_step(tail_q, -1 - k)][entry_w-1];
    assign age_caddr[k+1] = mem_q[ptr_step(tail_q, -1 - k)][caddr_lo +: caddr_width_p];
    assign age_data[k+1]  = mem_q[ptr_step(tail_q, -1 - k)][data_lo +: dword_width_p];
    assign age_mask[k+1]  = mem_q[ptr_step(tail_q, -1 - k)][mask_w-1:0];
  end

  always_comb begin
    age_hit   = '0;
    snoop_hit = snoop_v_i & v_tl_i & (addr_tl_i[block_offset_width_p +: sidx_w] == snoop_index_i);
    for (int k = 0; k <= els_p; k++) begin
      if (age_v[k] && v_tl_i && (((age_caddr[k] ^ addr_tl_i) >> off_w) == '0)) age_hit[k] = 1'b1;
      if (snoop_v_i && age_v[k] && !age_snoop[k]
          && (age_caddr[k][block_offset_width_p +: sidx_w] == snoop_index_i)) snoop_hit = 1'b1;
    end
  end

  assign snoop_match_o = reset_n_i & snoop_hit;

  bp_be_dcache_wbuf_bypass #(
    .n_p           (els_p + 1),
    .dword_width_p (dword_width_p)
  ) bypass (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .hit_i         (age_hit),
    .data_i        (age_data),
    .mask_i        (age_mask),
    .data_tv_i     (data_tv_i),
    .data_merged_o (data_merged_o)
  );

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(wbuf_if.v_i && full && !wbuf_if.yumi_i));
  a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    wbuf_if.yumi_i |-> wbuf_if.v_o);
endmodule
